whack_game_core: RTL and testbench

Parametrised game engine for the whack-a-mole board; replaces the fixed 4-LED combinational point counter.
- Generalises to N_MOLES positions.
- Adds timed mole lifetimes, gap periods, a bounded round timer, saturating score, no-repeat mole selection, and game-over/restart control.
- Consumes the LFSR random word and the debounced one-shot button pulses.
- Drives the mole LEDs, plus the score feeding the binary-to-BCD/7-segment path.

---
 rtl/whack_game_core.sv | 238 +++++++++++++++++++++++
 tb/tb_whack_game_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/whack_game_core.sv
// Whack-a-mole game engine: tick generation, mole spawn/lifetime/gap sequencing,
// round timer, saturating score and game-over/restart control for N_MOLES positions.
module whack_game_core #(
    parameter int N_MOLES     = 4,
    parameter int IDX_W       = 2,
    parameter int SCORE_W     = 8,
    parameter int TICK_DIV    = 50000000,
    parameter int MOLE_TICKS  = 3,
    parameter int GAP_TICKS   = 1,
    parameter int ROUND_TICKS = 60,
    parameter int ROUND_W     = 8
) (
    input  logic               kartclk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         rnd,
    input  logic [N_MOLES-1:0] btn,
    output logic [N_MOLES-1:0] mole_led,
    output logic [SCORE_W-1:0] score,
    output logic [ROUND_W-1:0] time_left,
    output logic               game_active,
    output logic               game_over,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    localparam int TICK_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int PH_MAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
    localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]    PH_MOLE     = PH_W'(MOLE_TICKS);
    localparam logic [PH_W-1:0]    PH_GAP      = PH_W'(GAP_TICKS);
    localparam logic [ROUND_W-1:0] ROUND_INIT  = ROUND_W'(ROUND_TICKS);
    localparam logic [IDX_W:0]     N_EXT       = (IDX_W + 1)'(N_MOLES);
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(N_MOLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_UP    = 3'd2,
        S_GAP   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t               r_state;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [PH_W-1:0]      r_phase;
    logic [IDX_W-1:0]     r_idx;
    logic [SCORE_W-1:0]   r_score;
    logic [ROUND_W-1:0]   r_time_left;
    logic [N_MOLES-1:0]   r_mole_led;
    logic                 r_game_active;
    logic                 r_game_over;
    logic                 r_hit_pulse;
    logic                 r_miss_pulse;

    state_t               w_fsm_next;
    state_t               w_state_next;
    logic [PH_W-1:0]      w_phase_next;
    logic [IDX_W-1:0]     w_idx_next;
    logic [SCORE_W-1:0]   w_score_next;
    logic [ROUND_W-1:0]   w_time_next;
    logic                 w_hit_next;
    logic                 w_miss_next;
    logic                 w_active;
    logic                 w_tick;
    logic                 w_start_round;
    logic                 w_round_end;
    logic                 w_btn_any;
    logic                 w_btn_hit;
    logic [IDX_W:0]       w_raw;
    logic [IDX_W-1:0]     w_mod;
    logic [IDX_W-1:0]     w_spawn_idx;
    logic                 w_unused_rnd;

    function automatic logic [N_MOLES-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        logic [N_MOLES-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign w_unused_rnd  = ^rnd[7:IDX_W];
    assign w_active      = (r_state == S_SPAWN) || (r_state == S_UP) || (r_state == S_GAP);
    assign w_tick        = w_active && (r_tick_cnt == TICK_LAST);
    assign w_start_round = start && ((r_state == S_IDLE) || (r_state == S_OVER));
    assign w_round_end   = w_tick && (r_time_left <= ROUND_W'(1));
    assign w_btn_any     = |btn;
    assign w_btn_hit     = (r_state == S_UP) && (btn == f_onehot(r_idx));
    assign w_raw         = {1'b0, rnd[IDX_W-1:0]};

    // Fold the random index into range, then step past the previous position.
    always_comb begin
        w_mod       = '0;
        w_spawn_idx = '0;
        if (w_raw >= N_EXT) begin
            w_mod = IDX_W'(w_raw - N_EXT);
        end else begin
            w_mod = w_raw[IDX_W-1:0];
        end
        if (w_mod != r_idx) begin
            w_spawn_idx = w_mod;
        end else if (w_mod == IDX_LAST) begin
            w_spawn_idx = '0;
        end else begin
            w_spawn_idx = w_mod + IDX_W'(1);
        end
    end

    // Mole sequencing; the round timer expiring overrides whatever the FSM chose.
    always_comb begin
        w_fsm_next   = r_state;
        w_phase_next = r_phase;
        w_idx_next   = r_idx;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_fsm_next = S_SPAWN;
                end else begin
                    w_fsm_next = r_state;
                end
            end
            S_SPAWN: begin
                w_idx_next   = w_spawn_idx;
                w_phase_next = PH_MOLE;
                w_fsm_next   = S_UP;
            end
            S_UP: begin
                if (w_btn_hit || (w_tick && (r_phase <= PH_W'(1)))) begin
                    w_phase_next = PH_GAP;
                    w_fsm_next   = (GAP_TICKS == 0) ? S_SPAWN : S_GAP;
                end else if (w_tick) begin
                    w_phase_next = r_phase - PH_W'(1);
                end else begin
                    w_phase_next = r_phase;
                end
            end
            S_GAP: begin
                if (w_tick && (r_phase <= PH_W'(1))) begin
                    w_fsm_next = S_SPAWN;
                end else if (w_tick) begin
                    w_phase_next = r_phase - PH_W'(1);
                end else begin
                    w_phase_next = r_phase;
                end
            end
            default: begin
                w_fsm_next = S_IDLE;
            end
        endcase
        w_state_next = w_round_end ? S_OVER : w_fsm_next;
    end

    // Score, hit/miss pulses and round timer next values.
    always_comb begin
        w_score_next = r_score;
        w_hit_next   = 1'b0;
        w_miss_next  = 1'b0;
        w_time_next  = r_time_left;
        if (w_start_round) begin
            w_score_next = '0;
            w_time_next  = ROUND_INIT;
        end else if (w_round_end) begin
            w_time_next  = '0;
        end else if (w_active) begin
            if (w_tick) begin
                w_time_next = r_time_left - ROUND_W'(1);
            end else begin
                w_time_next = r_time_left;
            end
            if (w_btn_hit) begin
                w_hit_next   = 1'b1;
                w_score_next = (r_score == SCORE_MAX) ? r_score : r_score + SCORE_W'(1);
            end else if (w_btn_any) begin
                w_miss_next  = 1'b1;
                w_score_next = (r_score == '0) ? r_score : r_score - SCORE_W'(1);
            end else begin
                w_score_next = r_score;
            end
        end else begin
            w_score_next = r_score;
        end
    end

    // Game tick divider: runs only while a round is active.
    always_ff @(posedge kartclk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_start_round) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else if (w_active) begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end else begin
            r_tick_cnt <= r_tick_cnt;
        end
    end

    // State, game registers and registered outputs.
    always_ff @(posedge kartclk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_phase       <= '0;
            r_idx         <= '0;
            r_score       <= '0;
            r_time_left   <= ROUND_INIT;
            r_mole_led    <= '0;
            r_game_active <= 1'b0;
            r_game_over   <= 1'b0;
            r_hit_pulse   <= 1'b0;
            r_miss_pulse  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_phase       <= w_phase_next;
            r_idx         <= w_idx_next;
            r_score       <= w_score_next;
            r_time_left   <= w_time_next;
            r_mole_led    <= (w_state_next == S_UP) ? f_onehot(w_idx_next) : '0;
            r_game_active <= (w_state_next == S_SPAWN) || (w_state_next == S_UP) ||
                             (w_state_next == S_GAP);
            r_game_over   <= (w_state_next == S_OVER);
            r_hit_pulse   <= w_hit_next;
            r_miss_pulse  <= w_miss_next;
        end
    end

    assign mole_led    = r_mole_led;
    assign score       = r_score;
    assign time_left   = r_time_left;
    assign game_active = r_game_active;
    assign game_over   = r_game_over;
    assign hit_pulse   = r_hit_pulse;
    assign miss_pulse  = r_miss_pulse;

endmodule

// File: tb/tb_whack_game_core.sv
// Directed bench for whack_game_core: one board with the small-tick configuration
// and a second with no gap and a slow tick for the score saturation run.
module tb_whack_game_core;

    logic       clk;
    logic       rst, start;
    logic [7:0] rnd;
    logic [3:0] btn;
    logic [3:0] mole_led;
    logic [7:0] score, time_left;
    logic       game_active, game_over, hit_pulse, miss_pulse;

    logic       rst_b, start_b;
    logic [7:0] rnd_b;
    logic [3:0] btn_b;
    logic [3:0] mole_led_b;
    logic [7:0] score_b, time_left_b;
    logic       game_active_b, game_over_b, hit_pulse_b, miss_pulse_b;

    int tests;
    int fails;

    whack_game_core #(
        .N_MOLES(4), .IDX_W(2), .SCORE_W(8), .TICK_DIV(4), .MOLE_TICKS(3),
        .GAP_TICKS(1), .ROUND_TICKS(20), .ROUND_W(8)
    ) dut (
        .kartclk(clk), .rst(rst), .start(start), .rnd(rnd), .btn(btn),
        .mole_led(mole_led), .score(score), .time_left(time_left),
        .game_active(game_active), .game_over(game_over),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    whack_game_core #(
        .N_MOLES(4), .IDX_W(2), .SCORE_W(8), .TICK_DIV(1000), .MOLE_TICKS(3),
        .GAP_TICKS(0), .ROUND_TICKS(10), .ROUND_W(8)
    ) dut_sat (
        .kartclk(clk), .rst(rst_b), .start(start_b), .rnd(rnd_b), .btn(btn_b),
        .mole_led(mole_led_b), .score(score_b), .time_left(time_left_b),
        .game_active(game_active_b), .game_over(game_over_b),
        .hit_pulse(hit_pulse_b), .miss_pulse(miss_pulse_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_led"},    32'(mole_led),    32'h0);
        chk({tag, "_score"},  32'(score),       32'h0);
        chk({tag, "_time"},   32'(time_left),   32'd20);
        chk({tag, "_active"}, 32'(game_active), 32'h0);
        chk({tag, "_over"},   32'(game_over),   32'h0);
        chk({tag, "_hit"},    32'(hit_pulse),   32'h0);
        chk({tag, "_miss"},   32'(miss_pulse),  32'h0);
    endtask

    initial begin
        logic [1:0] m_last;
        logic [1:0] m_idx;
        logic [3:0] m_led;
        int         m_score;

        tests = 0;
        fails = 0;
        rst = 1'b1; start = 1'b0; rnd = 8'h00; btn = 4'b0000;
        rst_b = 1'b1; start_b = 1'b0; rnd_b = 8'h00; btn_b = 4'b0000;
        #1;
        step();
        step();
        chk_reset("reset");
        rst = 1'b0; rst_b = 1'b0;
        step();

        // Round start and first mole lifetime
        rnd = 8'h06; start = 1'b1; step();
        start = 1'b0;
        chk("spawn_active", 32'(game_active), 32'h1);
        chk("spawn_led",    32'(mole_led),    32'h0);
        step();
        chk("up_led2",      32'(mole_led),    32'h4);
        chk("up_time20",    32'(time_left),   32'd20);
        repeat (10) step();
        chk("lit_end_led",  32'(mole_led),    32'h4);
        chk("lit_end_time", 32'(time_left),   32'd18);
        step();
        chk("escape_led",   32'(mole_led),    32'h0);
        chk("escape_time",  32'(time_left),   32'd17);
        chk("escape_score", 32'(score),       32'd0);
        repeat (4) step();
        chk("gap_led",      32'(mole_led),    32'h0);
        chk("gap_time",     32'(time_left),   32'd16);
        step();
        chk("norepeat_led3", 32'(mole_led),   32'h8);

        // Miss at zero, then hits and the no-repeat respawn
        btn = 4'b0001; step();
        chk("miss0_pulse",  32'(miss_pulse),  32'h1);
        chk("miss0_hit",    32'(hit_pulse),   32'h0);
        chk("miss0_score",  32'(score),       32'd0);
        chk("miss0_led",    32'(mole_led),    32'h8);
        btn = 4'b1000; step();
        chk("hit1_pulse",   32'(hit_pulse),   32'h1);
        chk("hit1_miss",    32'(miss_pulse),  32'h0);
        chk("hit1_score",   32'(score),       32'd1);
        chk("hit1_led",     32'(mole_led),    32'h0);
        btn = 4'b0000; step();
        chk("respawn_hit",  32'(hit_pulse),   32'h0);
        chk("respawn_time", 32'(time_left),   32'd15);
        step();
        chk("up2_led",      32'(mole_led),    32'h4);
        btn = 4'b0100; step();
        chk("hit2_pulse",   32'(hit_pulse),   32'h1);
        chk("hit2_score",   32'(score),       32'd2);
        chk("hit2_led",     32'(mole_led),    32'h0);
        btn = 4'b0000; step(); step();
        chk("gap2_time",    32'(time_left),   32'd14);
        step();
        chk("up3_led",      32'(mole_led),    32'h8);
        btn = 4'b1001; step();
        chk("combo_miss",   32'(miss_pulse),  32'h1);
        chk("combo_hit",    32'(hit_pulse),   32'h0);
        chk("combo_score",  32'(score),       32'd1);
        chk("combo_led",    32'(mole_led),    32'h8);
        btn = 4'b1000; step();
        chk("hit3_score",   32'(score),       32'd2);
        btn = 4'b0010; rnd = 8'h05; step();
        chk("gapmiss_pulse", 32'(miss_pulse), 32'h1);
        chk("gapmiss_score", 32'(score),      32'd1);
        chk("gapmiss_time",  32'(time_left),  32'd13);
        btn = 4'b0000; step();
        chk("up4_led1",     32'(mole_led),    32'h2);
        repeat (16) step();
        chk("up5_led2",     32'(mole_led),    32'h4);
        chk("up5_time",     32'(time_left),   32'd9);
        repeat (34) step();
        chk("preend_time",  32'(time_left),   32'd1);
        chk("preend_over",  32'(game_over),   32'h0);
        chk("preend_led",   32'(mole_led),    32'h4);

        // Round end overrides a press in the same cycle
        btn = 4'b1111; step();
        chk("end_over",     32'(game_over),   32'h1);
        chk("end_active",   32'(game_active), 32'h0);
        chk("end_time",     32'(time_left),   32'd0);
        chk("end_led",      32'(mole_led),    32'h0);
        chk("end_score",    32'(score),       32'd1);
        chk("end_miss",     32'(miss_pulse),  32'h0);
        btn = 4'b0001; step();
        chk("over_score",   32'(score),       32'd1);
        chk("over_miss",    32'(miss_pulse),  32'h0);
        chk("over_hold",    32'(game_over),   32'h1);
        btn = 4'b0000; rnd = 8'h06; start = 1'b1; step();
        start = 1'b0;
        chk("restart_score", 32'(score),      32'd0);
        chk("restart_time",  32'(time_left),  32'd20);
        chk("restart_active", 32'(game_active), 32'h1);
        chk("restart_over",  32'(game_over),  32'h0);
        step();
        chk("r_up1_led",    32'(mole_led),    32'h8);
        btn = 4'b1000; step();
        btn = 4'b0000; repeat (2) step();
        step();
        chk("r_up2_led",    32'(mole_led),    32'h4);
        btn = 4'b0100; step();
        btn = 4'b0000; repeat (3) step();
        chk("r_up3_led",    32'(mole_led),    32'h8);
        btn = 4'b1000; step();
        btn = 4'b0000; repeat (3) step();
        chk("r_up4_led",    32'(mole_led),    32'h4);
        chk("r_up4_score",  32'(score),       32'd3);

        // Reset mid-UP overrides start and a correct press
        rst = 1'b1; start = 1'b1; btn = 4'b0100; step();
        chk_reset("midrst");
        rst = 1'b0; btn = 4'b0000; step();
        chk("rs_active",    32'(game_active), 32'h1);
        start = 1'b0; step();
        chk("rs_up_led",    32'(mole_led),    32'h4);
        start = 1'b1; step();
        start = 1'b0;
        chk("ignstart_led",    32'(mole_led),    32'h4);
        chk("ignstart_active", 32'(game_active), 32'h1);

        // Saturation run on the second board
        start_b = 1'b1; step();
        start_b = 1'b0;
        m_last  = 2'd0;
        m_score = 0;
        for (int k = 1; k <= 256; k++) begin
            step();
            m_idx = rnd_b[1:0];
            if (m_idx == m_last) m_idx = m_idx + 2'd1;
            m_last = m_idx;
            m_led  = 4'b0001 << m_idx;
            chk("sat_led", 32'(mole_led_b), 32'(m_led));
            btn_b = m_led; step();
            btn_b = 4'b0000;
            if (m_score < 255) m_score++;
            chk("sat_hit",   32'(hit_pulse_b), 32'h1);
            chk("sat_score", 32'(score_b),     32'(m_score));
        end
        chk("sat_final",    32'(score_b),      32'd255);
        chk("sat_nomiss",   32'(miss_pulse_b), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
